// File: rtl/mem_responder.sv
// mem_responder: multi-cycle word memory target with wait states, byte-enabled stores and error responses
module mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        ack,
    output logic        err,
    output logic [31:0] rdata,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_nxt;
    logic [3:0] cnt;
    logic we_q, err_q, bad, access;
    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0] wdata_q;
    logic [3:0] be_q;
    logic [31:0] mem [(1 << ADDR_WIDTH)];
    assign bad = (addr[1:0] != 2'b00) || ((addr >> (ADDR_WIDTH + 2)) != 32'd0);
    assign access = (state == WAIT) && (cnt == 4'd0);
    // next state and handshake outputs; ack/err come straight from RESP
    always_comb begin
        state_nxt = (state == IDLE) ? (req ? (bad ? RESP : WAIT) : IDLE) :
                    (state == WAIT) ? ((cnt == 4'd0) ? RESP : WAIT) : IDLE;
        ack = state == RESP;
        err = ack && err_q;
        busy = state != IDLE;
    end
    // state register, request capture, wait counter and load data register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt <= 4'd0;
            we_q <= 1'b0;
            err_q <= 1'b0;
            idx <= '0;
            wdata_q <= 32'd0;
            be_q <= 4'd0;
            rdata <= 32'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req) begin
                we_q <= we;
                err_q <= bad;
                idx <= addr[ADDR_WIDTH+1:2];
                wdata_q <= wdata;
                be_q <= be;
                cnt <= bad ? 4'd0 : 4'(WAIT_STATES);
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (access && !we_q) rdata <= mem[idx];
        end
    end
    // storage write port; kept out of reset so contents survive it
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) if (access && we_q && be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder (WAIT_STATES 2 and 0 instances)
module tb_mem_responder;
    localparam int AW = 10;
    localparam int WS = 2;
    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
        int          edges;
    } exp_t;
    logic clk = 1'b0;
    logic reset_n = 1'b1, reset0_n = 1'b1;
    logic req = 1'b0, we = 1'b0, ack, err, busy;
    logic [31:0] addr = 32'd0, wdata = 32'd0, rdata;
    logic [3:0] be = 4'd0;
    logic req0 = 1'b0, we0 = 1'b0, ack0, err0, busy0;
    logic [31:0] addr0 = 32'd0, wdata0 = 32'd0, rdata0;
    logic [3:0] be0 = 4'd0;
    int passed = 0, total = 0;
    exp_t q[$], q0[$];
    logic [31:0] model[int], model0[int];
    logic [31:0] exp_rdata = 32'd0, exp_rdata0 = 32'd0;
    int n0 = 0;

    mem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .be(be), .ack(ack), .err(err), .rdata(rdata), .busy(busy)
    );
    mem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset0_n), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .be(be0), .ack(ack0), .err(err0), .rdata(rdata0), .busy(busy0)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] b);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    function automatic logic is_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> (AW + 2)) != 32'd0);
    endfunction

    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] b, input string nm);
        exp_t e;
        int edges = 0;
        logic got = 1'b0;
        e.err = is_bad(a);
        e.edges = e.err ? 0 : WS + 1;
        if (!e.err) begin
            if (w) model[int'(a >> 2)] = merge(model.exists(int'(a >> 2)) ? model[int'(a >> 2)] : 32'd0, wd, b);
            else exp_rdata = model[int'(a >> 2)];
        end
        e.rdata = exp_rdata;
        q.push_back(e);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = wd; be = b;
        @(posedge clk);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) begin
                total++;
                if (busy !== 1'b1) $display("FAIL %s busy: got %b want 1", nm, busy); else passed++;
            end
            if (ack) begin got = 1'b1; break; end
            we = $urandom_range(0, 1); addr = $urandom; wdata = $urandom; be = 4'($urandom);
            @(posedge clk);
            edges++;
        end
        e = q.pop_front();
        total++;
        if (!got) $display("FAIL %s ack timeout: no ack within 40 cycles", nm);
        else begin
            passed++;
            total += 3;
            if (err !== e.err) $display("FAIL %s err: got %b want %b", nm, err, e.err); else passed++;
            if (edges != e.edges) $display("FAIL %s latency: got %0d want %0d", nm, edges, e.edges); else passed++;
            if (rdata !== e.rdata) $display("FAIL %s rdata: got %h want %h", nm, rdata, e.rdata); else passed++;
        end
        req = 1'b0;
        @(negedge clk);
        total++;
        if (ack !== 1'b0 || err !== 1'b0 || busy !== 1'b0)
            $display("FAIL %s after ack: ack/err/busy got %b%b%b want 000", nm, ack, err, busy);
        else passed++;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #3;
        reset_n = 1'b0; reset0_n = 1'b0;
        #1;
        total += 2;
        if ({ack, err, busy} !== 3'b000) $display("FAIL reset flags: ack/err/busy got %b%b%b want 000", ack, err, busy); else passed++;
        if (rdata !== 32'd0) $display("FAIL reset rdata: got %h want 0", rdata); else passed++;
        total++;
        if ({ack0, err0, busy0, rdata0} !== 35'd0) $display("FAIL reset dut0: got %b%b%b %h want 000 0", ack0, err0, busy0, rdata0); else passed++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1; reset0_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({ack, err, busy} !== 3'b000 || rdata !== 32'd0)
                $display("FAIL idle %0d: ack/err/busy got %b%b%b rdata %h want 000 0", i, ack, err, busy, rdata);
            else passed++;
        end
    endtask

    task automatic test_store_load();
        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "store 0x10");
        txn(1'b0, 32'h10, 32'h0, 4'h0, "load 0x10");
        total++;
        if (rdata !== 32'hDEADBEEF) $display("FAIL load 0x10 value: got %h want deadbeef", rdata); else passed++;
    endtask

    task automatic test_byte_enables();
        txn(1'b1, 32'h20, 32'h11223344, 4'hF, "store 0x20");
        txn(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, "store 0x20 be5");
        txn(1'b0, 32'h20, 32'h0, 4'hF, "load 0x20");
        total++;
        if (rdata !== 32'h11BB33DD) $display("FAIL be merge: got %h want 11bb33dd", rdata); else passed++;
        txn(1'b1, 32'h20, 32'h55555555, 4'h0, "store 0x20 be0");
        txn(1'b0, 32'h20, 32'h0, 4'h0, "load 0x20 after be0");
    endtask

    task automatic test_errors();
        txn(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, "store 0x0");
        txn(1'b0, 32'h6, 32'h0, 4'h0, "load 0x6 misaligned");
        txn(1'b1, 32'h1000, 32'h12345678, 4'hF, "store 0x1000 range");
        txn(1'b1, 32'h8000_0000, 32'h9ABCDEF0, 4'hF, "store top bit range");
        txn(1'b0, 32'h0, 32'h0, 4'h0, "load 0x0 after errors");
    endtask

    task automatic test_mid_reset();
        txn(1'b1, 32'h40, 32'h0BADF00D, 4'hF, "store 0x40");
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h40; wdata = 32'hFFFFFFFF; be = 4'hF;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        req = 1'b0;
        exp_rdata = 32'd0;
        #1;
        total++;
        if ({ack, busy} !== 2'b00 || rdata !== 32'd0) $display("FAIL mid reset: ack/busy got %b%b rdata %h want 00 0", ack, busy, rdata); else passed++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (ack !== 1'b0 || busy !== 1'b0) $display("FAIL mid reset no ack %0d: ack/busy got %b%b want 00", i, ack, busy); else passed++;
        end
        txn(1'b0, 32'h40, 32'h0, 4'h0, "load 0x40 after abort");
    endtask

    task automatic issue0(input logic w, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] b);
        exp_t e;
        e.err = is_bad(a);
        e.edges = e.err ? 2 : 3;
        if (!e.err) begin
            if (w) model0[int'(a >> 2)] = merge(model0.exists(int'(a >> 2)) ? model0[int'(a >> 2)] : 32'd0, wd, b);
            else exp_rdata0 = model0[int'(a >> 2)];
        end
        e.rdata = exp_rdata0;
        q0.push_back(e);
        req0 = 1'b1; we0 = w; addr0 = a; wdata0 = wd; be0 = b;
    endtask

    task automatic next0();
        case (n0)
            0: issue0(1'b1, 32'h8, 32'h01234567, 4'hF);
            1: issue0(1'b0, 32'h8, 32'h0, 4'h0);
            2: issue0(1'b1, 32'h8, 32'hFFEEDDCC, 4'b0011);
            3: issue0(1'b0, 32'h2, 32'h0, 4'h0);
            4: issue0(1'b0, 32'h8, 32'h0, 4'h0);
            5: issue0(1'b1, 32'h3000, 32'h77777777, 4'hF);
            default: req0 = 1'b0;
        endcase
        n0++;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int done = 0, gap = 0;
        @(negedge clk);
        next0();
        for (int c = 0; c < 100 && done < 6; c++) begin
            @(negedge clk);
            gap++;
            if (ack0) begin
                e = q0.pop_front();
                total += 2;
                if (err0 !== e.err) $display("FAIL b2b %0d err: got %b want %b", done, err0, e.err); else passed++;
                if (rdata0 !== e.rdata) $display("FAIL b2b %0d rdata: got %h want %h", done, rdata0, e.rdata); else passed++;
                if (done > 0) begin
                    total++;
                    if (gap != e.edges) $display("FAIL b2b %0d ack spacing: got %0d want %0d", done, gap, e.edges); else passed++;
                end
                gap = 0;
                done++;
                next0();
            end else if (busy0) begin
                we0 = $urandom_range(0, 1); addr0 = $urandom; wdata0 = $urandom; be0 = 4'($urandom);
            end
        end
        total++;
        if (done != 6) $display("FAIL b2b timeout: got %0d acks want 6", done); else passed++;
        total++;
        if (rdata0 !== 32'h0123DDCC) $display("FAIL b2b final rdata: got %h want 0123ddcc", rdata0); else passed++;
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_enables();
        test_errors();
        test_mid_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
